// File: rtl/tx_arb_pkg.sv
// Shared state encoding, default block width and width helpers for the TX block arbiter.
package tx_arb_pkg;

    localparam int unsigned DEF_BLOCK_W = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_OFFER = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        OFFER     = ST_OFFER,
        WAIT_DONE = ST_WAIT
    } arb_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((64'd1 << width) < 64'(value)) width++;
        return width;
    endfunction

    // Index width for n entries, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set bit of 'full' after 'last', wrapping modulo N_REQ.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int unsigned  N_REQ = 2,
    localparam int unsigned IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] full,
    input  logic [IW-1:0]    last,
    output logic             found_c,
    output logic [IW-1:0]    idx_c
);

    // Scan last+1 .. last+N_REQ; the wrap is an explicit subtract so non-power-of-2 counts work.
    always_comb begin
        int unsigned cand;
        found_c = 1'b0;
        idx_c   = '0;
        cand    = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = 32'(last) + k;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!found_c && full[IW'(cand)]) begin
                found_c = 1'b1;
                idx_c   = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/tx_block_arbiter.sv
// Round-robin sharing of the 128-bit block serializer between N_REQ producers, with watchdog abort.
module tx_block_arbiter
    import tx_arb_pkg::*;
#(
    parameter int unsigned  N_REQ   = 2,
    parameter int unsigned  BLOCK_W = DEF_BLOCK_W,
    parameter int unsigned  TIMEOUT = 4096,
    localparam int unsigned GW      = idx_w(N_REQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*BLOCK_W-1:0] req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic [BLOCK_W-1:0]       blk_data,
    output logic                     blk_empty,
    input  logic                     blk_read,
    input  logic                     shift_done,
    output logic [GW-1:0]            grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int unsigned WD_W = clog2(TIMEOUT) + 1;

    arb_state_e         state_q, state_n;
    logic [BLOCK_W-1:0] slot_q [N_REQ];
    logic [BLOCK_W-1:0] slot_n [N_REQ];
    logic [N_REQ-1:0]   full_q, full_n;
    logic [GW-1:0]      last_q, last_n;
    logic [WD_W-1:0]    wd_q, wd_n;
    logic [BLOCK_W-1:0] blk_data_n;
    logic               blk_empty_n;
    logic [GW-1:0]      grant_n;
    logic               terr_n;
    logic [N_REQ-1:0]   ready_n;
    logic               pick_found_c;
    logic [GW-1:0]      pick_idx_c;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .full    (full_q),
        .last    (last_q),
        .found_c (pick_found_c),
        .idx_c   (pick_idx_c)
    );

    // Next-state: slot capture, grant/offer handshake and watchdog.
    always_comb begin
        state_n     = state_q;
        slot_n      = slot_q;
        full_n      = full_q;
        last_n      = last_q;
        wd_n        = wd_q;
        blk_data_n  = blk_data;
        blk_empty_n = blk_empty;
        grant_n     = grant_id;
        terr_n      = timeout_err;
        ready_n     = '0;

        // Only slots empty at cycle start accept; a slot freed this cycle refills next cycle.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && !full_q[i]) begin
                slot_n[i]  = req_data[i*BLOCK_W +: BLOCK_W];
                full_n[i]  = 1'b1;
                ready_n[i] = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (pick_found_c) begin
                    grant_n     = pick_idx_c;
                    blk_data_n  = slot_q[pick_idx_c];
                    blk_empty_n = 1'b0;
                    state_n     = OFFER;
                end
            end
            OFFER: begin
                if (blk_read) begin
                    full_n[grant_id] = 1'b0;
                    blk_empty_n      = 1'b1;
                    wd_n             = '0;
                    state_n          = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (shift_done) begin
                    last_n  = grant_id;
                    state_n = IDLE;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    // Abandon the block; it is not retried.
                    terr_n  = 1'b1;
                    last_n  = grant_id;
                    state_n = IDLE;
                end else begin
                    wd_n = wd_q + WD_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs; synchronous active-low reset discards all held blocks.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            for (int unsigned i = 0; i < N_REQ; i++) slot_q[i] <= '0;
            full_q      <= '0;
            last_q      <= GW'(N_REQ - 1);
            wd_q        <= '0;
            req_ready   <= '0;
            blk_data    <= '0;
            blk_empty   <= 1'b1;
            grant_id    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_n;
            slot_q      <= slot_n;
            full_q      <= full_n;
            last_q      <= last_n;
            wd_q        <= wd_n;
            req_ready   <= ready_n;
            blk_data    <= blk_data_n;
            blk_empty   <= blk_empty_n;
            grant_id    <= grant_n;
            busy        <= (state_n != IDLE);
            timeout_err <= terr_n;
        end
    end

endmodule

// File: tb/tb_tx_block_arbiter.sv
// Scoreboard bench for tx_block_arbiter: transaction-level model predicts captures, offers and status.
`timescale 1ns/1ps
module tb_tx_block_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned BW = 128;
    localparam int          TO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*BW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic [BW-1:0]   blk_data;
    logic            blk_empty;
    logic            blk_read;
    logic            shift_done;
    logic [0:0]      grant_id;
    logic            busy;
    logic            timeout_err;

    tx_block_arbiter #(.N_REQ(N), .BLOCK_W(BW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .blk_data    (blk_data),
        .blk_empty   (blk_empty),
        .blk_read    (blk_read),
        .shift_done  (shift_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [0:0]    g;
        logic [BW-1:0] d;
    } offer_t;

    typedef struct packed {
        logic          empty;
        logic          busy;
        logic          terr;
        logic [BW-1:0] data;
    } stat_t;

    offer_t       offer_q[$];
    stat_t        stat_q[$];
    logic [N-1:0] ready_q[$];

    int errors = 0;
    int checks = 0;
    logic mon_on = 1'b0;

    // Reference model: who owns the serializer and what each producer slot holds.
    int            phase;      // 0 free, 1 block offered, 2 serializer shifting
    int            owner;
    int            m_last;
    int            read_cyc;
    int            cyc = 0;
    logic [N-1:0]  mfull;
    logic [BW-1:0] mdata [N];
    logic          mterr;
    logic [BW-1:0] mblk;
    logic          mempty;
    logic [N-1:0]  m_rdy;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Drive one clock edge worth of inputs, predict its effect, then move past that edge.
    task automatic step(input logic rst, input logic [N-1:0] v, input logic [BW-1:0] d0,
                        input logic [BW-1:0] d1, input logic rd, input logic sd);
        logic [N-1:0] old_full;
        int g;
        reset      = rst;
        req_valid  = v;
        req_data   = {d1, d0};
        blk_read   = rd;
        shift_done = sd;
        cyc++;
        m_rdy = '0;
        if (!rst) begin
            mfull  = '0;
            phase  = 0;
            m_last = N - 1;
            mterr  = 1'b0;
            mblk   = '0;
            mempty = 1'b1;
        end else begin
            old_full = mfull;
            case (phase)
                0: begin
                    g = -1;
                    for (int k = 1; k <= N; k++) begin
                        if (g < 0 && old_full[(m_last + k) % N]) g = (m_last + k) % N;
                    end
                    if (g >= 0) begin
                        owner  = g;
                        phase  = 1;
                        mblk   = mdata[g];
                        mempty = 1'b0;
                        offer_q.push_back('{g: 1'(g), d: mdata[g]});
                    end
                end
                1: if (rd) begin
                    mfull[owner] = 1'b0;
                    mempty       = 1'b1;
                    phase        = 2;
                    read_cyc     = cyc;
                end
                default: begin
                    if (sd) begin
                        m_last = owner;
                        phase  = 0;
                    end else if (cyc - read_cyc == TO) begin
                        mterr  = 1'b1;
                        m_last = owner;
                        phase  = 0;
                    end
                end
            endcase
            for (int i = 0; i < N; i++) begin
                if (v[i] && !old_full[i]) begin
                    mfull[i] = 1'b1;
                    mdata[i] = (i == 0) ? d0 : d1;
                    m_rdy[i] = 1'b1;
                end
            end
            if (m_rdy != '0) ready_q.push_back(m_rdy);
        end
        stat_q.push_back('{empty: mempty, busy: (phase != 0), terr: mterr, data: mblk});
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, 1'b0, 1'b0);
    endtask

    // Monitor: per-cycle status, plus capture pulses and new offers as they appear.
    initial begin
        logic  prev_empty;
        stat_t s;
        offer_t o;
        logic [N-1:0] r;
        prev_empty = 1'b1;
        wait (mon_on);
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (stat_q.size() == 0) begin
                check("status_queue_underflow", 128'(stat_q.size()), 128'(1));
            end else begin
                s = stat_q.pop_front();
                check("blk_empty", 128'(blk_empty), 128'(s.empty));
                check("busy", 128'(busy), 128'(s.busy));
                check("timeout_err", 128'(timeout_err), 128'(s.terr));
                check("blk_data", blk_data, s.data);
            end
            if (req_ready != '0) begin
                if (ready_q.size() == 0) begin
                    check("unexpected_req_ready", 128'(req_ready), 128'(0));
                end else begin
                    r = ready_q.pop_front();
                    check("req_ready", 128'(req_ready), 128'(r));
                end
            end
            if (prev_empty && !blk_empty) begin
                if (offer_q.size() == 0) begin
                    check("unexpected_offer", 128'(blk_empty), 128'(1));
                end else begin
                    o = offer_q.pop_front();
                    check("offer_grant_id", 128'(grant_id), 128'(o.g));
                    check("offer_data", blk_data, o.d);
                end
            end
            prev_empty = blk_empty;
        end
    end

    initial begin
        logic [N-1:0]  pv;
        logic [BW-1:0] pd [N];
        logic [BW-1:0] blk_a;
        logic [BW-1:0] blk_b;
        reset = 1'b0; req_valid = '0; req_data = '0; blk_read = 1'b0; shift_done = 1'b0;
        pv = '0; pd[0] = '0; pd[1] = '0;
        @(posedge clk);
        #2;
        mon_on = 1'b1;
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        step(1'b0, 2'b11, rnd128(), rnd128(), 1'b1, 1'b1);
        check("reset_grant_id", 128'(grant_id), 128'(0));
        check("reset_req_ready", 128'(req_ready), 128'(0));

        // Single request; blk_read on the offer edge must be ignored.
        step(1'b1, 2'b01, 128'h00112233445566778899AABBCCDDEEFF, '0, 1'b0, 1'b0);
        step(1'b1, '0, '0, '0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, '0, '0, '0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1);
        idle(2);

        // Contention: both valid together.
        step(1'b1, 2'b11, rnd128(), rnd128(), 1'b0, 1'b0);
        idle(2);
        step(1'b1, '0, '0, '0, 1'b1, 1'b0);
        idle(3);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, '0, '0, '0, 1'b1, 1'b0);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1);
        idle(2);

        // Backpressure: second block on requester 1 waits for the first to be read.
        blk_a = rnd128();
        blk_b = rnd128();
        step(1'b1, 2'b10, '0, blk_a, 1'b0, 1'b0);
        idle(1);
        for (int k = 0; k < 8; k++) step(1'b1, 2'b10, '0, blk_b, k == 1, k == 3);
        idle(1);
        step(1'b1, '0, '0, '0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1);
        idle(2);

        // Watchdog: withhold shift_done, then a late shift_done while the next block is offered.
        step(1'b1, 2'b11, rnd128(), rnd128(), 1'b0, 1'b0);
        idle(1);
        step(1'b1, '0, '0, '0, 1'b1, 1'b0);
        idle(18);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1);
        idle(2);
        step(1'b1, '0, '0, '0, 1'b1, 1'b0);
        idle(2);
        step(1'b1, '0, '0, '0, 1'b0, 1'b1);
        idle(2);

        // Mid-operation reset during shifting with slot 1 still full.
        step(1'b1, 2'b11, rnd128(), rnd128(), 1'b0, 1'b0);
        idle(1);
        step(1'b1, '0, '0, '0, 1'b1, 1'b0);
        idle(3);
        step(1'b0, '0, '0, '0, 1'b0, 1'b0);
        idle(6);

        // Fairness: both producers refilled continuously.
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++) if (!pv[i]) begin pv[i] = 1'b1; pd[i] = rnd128(); end
            step(1'b1, pv, pd[0], pd[1], ($urandom_range(1, 0) == 0), ($urandom_range(2, 0) == 0));
            pv = pv & ~m_rdy;
        end

        // Random traffic, spurious handshakes and occasional resets.
        for (int c = 0; c < 700; c++) begin
            for (int i = 0; i < N; i++) if (!pv[i] && $urandom_range(1, 0) == 0) begin
                pv[i] = 1'b1;
                pd[i] = rnd128();
            end
            step(($urandom_range(299, 0) != 0), pv, pd[0], pd[1],
                 ($urandom_range(2, 0) == 0), ($urandom_range(5, 0) == 0));
            pv = pv & ~m_rdy;
        end
        idle(4);

        @(negedge clk);
        #1;
        check("ready_queue_drained", 128'(ready_q.size()), 128'(0));
        check("offer_queue_drained", 128'(offer_q.size()), 128'(0));
        check("status_queue_drained", 128'(stat_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
